dac_spi_rx: RTL and testbench

DAC_SPI_RX -- requirements
Module: dac_spi_rx

---
 rtl/dac_spi_pkg.sv | 68 ++++++
 rtl/dac_spi_rx_if.sv | 18 +
 rtl/dac_spi_sync.sv | 43 ++++
 rtl/dac_spi_rx.sv | 193 +++++++++++++++++++
 tb/tb_dac_spi_rx.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dac_spi_pkg.sv
// ---------------------------------------------------------------------------
// dac_spi_pkg
// Shared definitions for the DAC SPI frame receiver: receiver state
// encoding, device selection, frame lengths per device, field bit positions
// inside the received shift register, and the idle levels the bus
// synchronizers start from.
// Ports: none (package).
// ---------------------------------------------------------------------------
package dac_spi_pkg;

  // Receiver sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2
  } rxState_t;

  // Supported frame formats.
  typedef enum logic [1:0] {
    DEV_LTC2630 = 2'd0,
    DEV_AD5640  = 2'd1,
    DEV_AD5660  = 2'd2
  } device_t;

  // Shift register holds the longest frame; the bit counter is 6 bits wide.
  localparam int SHIFT_W  = 24;
  localparam int BITCNT_W = 6;

  // Frame lengths per device.
  localparam int FRAME_BITS_LTC2630 = 24;
  localparam int FRAME_BITS_AD5640  = 16;
  localparam int FRAME_BITS_AD5660  = 24;

  // LTC2630 fields.
  localparam int LTC_CMD_MSB  = 23;
  localparam int LTC_CMD_LSB  = 20;
  localparam int LTC_ADDR_MSB = 19;
  localparam int LTC_ADDR_LSB = 16;
  localparam int LTC_CODE_MSB = 15;
  localparam int LTC_CODE_LSB = 0;

  // AD5660 fields (bits above the power-down field are don't-care).
  localparam int AD5660_PD_MSB   = 17;
  localparam int AD5660_PD_LSB   = 16;
  localparam int AD5660_CODE_MSB = 15;
  localparam int AD5660_CODE_LSB = 0;

  // AD5640 fields (14-bit code, left-justified on output).
  localparam int AD5640_PD_MSB   = 15;
  localparam int AD5640_PD_LSB   = 14;
  localparam int AD5640_CODE_MSB = 13;
  localparam int AD5640_CODE_LSB = 0;

  // Idle bus levels the synchronizers are preset to.
  localparam logic SCLK_RST   = 1'b0;
  localparam logic MOSI_RST   = 1'b0;
  localparam logic SYNC_N_RST = 1'b1;

  // Number of sclk edges that make a well-formed frame for a device.
  function automatic int frameBits(device_t dev);
    case (dev)
      DEV_AD5640: return FRAME_BITS_AD5640;
      DEV_AD5660: return FRAME_BITS_AD5660;
      default:    return FRAME_BITS_LTC2630;
    endcase
  endfunction

endpackage

// File: rtl/dac_spi_rx_if.sv
// ---------------------------------------------------------------------------
// dac_spi_rx_if
// Three-wire DAC SPI bus as seen by the receiver.
// Signals: sclk (serial clock), mosi (serial data), sync_n (frame select,
// active low).
// Modports: master drives the bus, slave observes it.
// ---------------------------------------------------------------------------
interface dac_spi_rx_if;
  import dac_spi_pkg::*;

  logic sclk;
  logic mosi;
  logic sync_n;

  modport master (output sclk, output mosi, output sync_n);
  modport slave  (input  sclk, input  mosi, input  sync_n);

endinterface

// File: rtl/dac_spi_sync.sv
// ---------------------------------------------------------------------------
// dac_spi_sync
// Brings one asynchronous bus wire into the clk domain through a chain of
// STAGES flops, then keeps one history flop so rising and falling edges can
// be seen as single-cycle strobes.
// Parameters: STAGES (synchronizer depth, >= 2), RST_VAL (idle level).
// Ports: clk, reset (sync, active high), i_async (raw wire),
//        o_sync (synchronized level), o_rise / o_fall (edge strobes).
// ---------------------------------------------------------------------------
module dac_spi_sync
  import dac_spi_pkg::*;
#(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_stages;
  logic              r_hist;

  // Synchronizer chain plus history flop; reset parks both at the idle
  // level so leaving reset on an idle bus produces no spurious edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stages <= {STAGES{RST_VAL}};
      r_hist   <= RST_VAL;
    end else begin
      r_stages <= {r_stages[STAGES-2:0], i_async};
      r_hist   <= r_stages[STAGES-1];
    end
  end

  assign o_sync = r_stages[STAGES-1];
  assign o_rise =  o_sync & ~r_hist;
  assign o_fall = ~o_sync &  r_hist;

endmodule

// File: rtl/dac_spi_rx.sv
// ---------------------------------------------------------------------------
// dac_spi_rx
// Passive receiver for a DAC SPI bus. Each frame bounded by sync_n is
// shifted in MSB-first on sclk rising edges, then checked for the exact bit
// count of the selected device. Good frames update dac_code/cmd/addr and
// pulse valid; bad frames pulse frame_err and leave the outputs alone.
// Parameters: DEVICE ("LTC2630", "AD5640", "AD5660"), SYNC_STAGES (2..4).
// Ports: clk (200 MHz sample clock), reset (sync, active high),
//        spi (dac_spi_rx_if.slave: sclk, mosi, sync_n),
//        dac_code[15:0] (left-justified code), cmd[3:0], addr[3:0],
//        valid / frame_err (one-cycle pulses),
//        frame_cnt / err_cnt [15:0] (statistics).
// Build option: define DAC_SPI_RX_STATS_EN to enable the statistics
// counters; otherwise frame_cnt/err_cnt read as zero and no counter flops
// exist.
// ---------------------------------------------------------------------------
module dac_spi_rx
  import dac_spi_pkg::*;
#(
  parameter string DEVICE      = "LTC2630",
  parameter int    SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  dac_spi_rx_if.slave        spi,
  output logic [15:0]        dac_code,
  output logic [3:0]         cmd,
  output logic [3:0]         addr,
  output logic               valid,
  output logic               frame_err,
  output logic [15:0]        frame_cnt,
  output logic [15:0]        err_cnt
);

  localparam device_t DEV = (DEVICE == "AD5640") ? DEV_AD5640 :
                            ((DEVICE == "AD5660") ? DEV_AD5660 : DEV_LTC2630);
  localparam int FRAME_BITS = frameBits(DEV);
  localparam logic [BITCNT_W-1:0] FRAME_TARGET = BITCNT_W'(FRAME_BITS);
  localparam logic [BITCNT_W-1:0] BITCNT_MAX   = '1;

  logic w_sclkRise;
  logic w_mosiSync;
  logic w_syncNRise;
  logic w_syncNFall;
  logic w_unusedSclkSync;
  logic w_unusedSclkFall;
  logic w_unusedMosiRise;
  logic w_unusedMosiFall;
  logic w_unusedSyncNSync;

  rxState_t             r_state;
  logic [SHIFT_W-1:0]   r_shift;
  logic [BITCNT_W-1:0]  r_bitCnt;
  logic [15:0]          r_dacCode;
  logic [3:0]           r_cmd;
  logic [3:0]           r_addr;
  logic                 r_valid;
  logic                 r_frameErr;

  dac_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(SCLK_RST)) u_syncSclk (
    .clk     (clk),
    .reset   (reset),
    .i_async (spi.sclk),
    .o_sync  (w_unusedSclkSync),
    .o_rise  (w_sclkRise),
    .o_fall  (w_unusedSclkFall)
  );

  dac_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(MOSI_RST)) u_syncMosi (
    .clk     (clk),
    .reset   (reset),
    .i_async (spi.mosi),
    .o_sync  (w_mosiSync),
    .o_rise  (w_unusedMosiRise),
    .o_fall  (w_unusedMosiFall)
  );

  dac_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(SYNC_N_RST)) u_syncSyncN (
    .clk     (clk),
    .reset   (reset),
    .i_async (spi.sync_n),
    .o_sync  (w_unusedSyncNSync),
    .o_rise  (w_syncNRise),
    .o_fall  (w_syncNFall)
  );

  // Frame sequencer with registered outputs. In SHIFT the sclk edge is
  // handled before the sync_n rise so a bit landing in the closing cycle
  // is still counted; CHECK then sees the final count. A new frame start
  // arriving while in CHECK goes straight back to SHIFT.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_bitCnt   <= '0;
      r_dacCode  <= '0;
      r_cmd      <= '0;
      r_addr     <= '0;
      r_valid    <= 1'b0;
      r_frameErr <= 1'b0;
    end else begin
      r_valid    <= 1'b0;
      r_frameErr <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_syncNFall) begin
            r_shift  <= '0;
            r_bitCnt <= '0;
            r_state  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (w_sclkRise) begin
            r_shift <= {r_shift[SHIFT_W-2:0], w_mosiSync};
            if (r_bitCnt != BITCNT_MAX) begin
              r_bitCnt <= r_bitCnt + 1'b1;
            end
          end
          if (w_syncNRise) begin
            r_state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (r_bitCnt == FRAME_TARGET) begin
            r_valid <= 1'b1;
            case (DEV)
              DEV_AD5640: begin
                r_cmd     <= {2'b00, r_shift[AD5640_PD_MSB:AD5640_PD_LSB]};
                r_addr    <= 4'd0;
                r_dacCode <= {r_shift[AD5640_CODE_MSB:AD5640_CODE_LSB], 2'b00};
              end
              DEV_AD5660: begin
                r_cmd     <= {2'b00, r_shift[AD5660_PD_MSB:AD5660_PD_LSB]};
                r_addr    <= 4'd0;
                r_dacCode <= r_shift[AD5660_CODE_MSB:AD5660_CODE_LSB];
              end
              default: begin
                r_cmd     <= r_shift[LTC_CMD_MSB:LTC_CMD_LSB];
                r_addr    <= r_shift[LTC_ADDR_MSB:LTC_ADDR_LSB];
                r_dacCode <= r_shift[LTC_CODE_MSB:LTC_CODE_LSB];
              end
            endcase
          end else begin
            r_frameErr <= 1'b1;
          end
          if (w_syncNFall) begin
            r_shift  <= '0;
            r_bitCnt <= '0;
            r_state  <= ST_SHIFT;
          end else begin
            r_state  <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign dac_code  = r_dacCode;
  assign cmd       = r_cmd;
  assign addr      = r_addr;
  assign valid     = r_valid;
  assign frame_err = r_frameErr;

`ifdef DAC_SPI_RX_STATS_EN
  logic [15:0] r_frameCnt;
  logic [15:0] r_errCnt;

  // Statistics follow the registered pulses and wrap naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frameCnt <= '0;
      r_errCnt   <= '0;
    end else begin
      if (r_valid) begin
        r_frameCnt <= r_frameCnt + 16'd1;
      end
      if (r_frameErr) begin
        r_errCnt <= r_errCnt + 16'd1;
      end
    end
  end

  assign frame_cnt = r_frameCnt;
  assign err_cnt   = r_errCnt;
`else
  assign frame_cnt = 16'd0;
  assign err_cnt   = 16'd0;
`endif

endmodule

// File: tb/tb_dac_spi_rx.sv
// ---------------------------------------------------------------------------
// tb_dac_spi_rx
// Drives one DAC SPI bus into three receivers (LTC2630, AD5640, AD5660) and
// compares their outputs to a frame-level reference model.
// ---------------------------------------------------------------------------
module tb_dac_spi_rx;

  localparam int SYNC_STAGES = 2;

  logic clk = 1'b0;
  logic reset;

  dac_spi_rx_if bus ();

  logic [15:0] dacCode [3];
  logic [3:0]  cmdO    [3];
  logic [3:0]  addrO   [3];
  logic        validO  [3];
  logic        errO    [3];
  logic [15:0] frameCnt[3];
  logic [15:0] errCnt  [3];

  int vectors     = 0;
  int miscompares = 0;

  int validSeen[3] = '{0, 0, 0};
  int errSeen  [3] = '{0, 0, 0};
  int bothSeen     = 0;

  int expCode  [3];
  int expCmd   [3];
  int expAddr  [3];
  int expValid [3] = '{0, 0, 0};
  int expErr   [3] = '{0, 0, 0};
  int expFrames[3];
  int expErrs  [3];

  always #5 clk = ~clk;

  dac_spi_rx #(.DEVICE("LTC2630"), .SYNC_STAGES(SYNC_STAGES)) u_ltc (
    .clk(clk), .reset(reset), .spi(bus),
    .dac_code(dacCode[0]), .cmd(cmdO[0]), .addr(addrO[0]),
    .valid(validO[0]), .frame_err(errO[0]),
    .frame_cnt(frameCnt[0]), .err_cnt(errCnt[0])
  );

  dac_spi_rx #(.DEVICE("AD5640"), .SYNC_STAGES(SYNC_STAGES)) u_ad5640 (
    .clk(clk), .reset(reset), .spi(bus),
    .dac_code(dacCode[1]), .cmd(cmdO[1]), .addr(addrO[1]),
    .valid(validO[1]), .frame_err(errO[1]),
    .frame_cnt(frameCnt[1]), .err_cnt(errCnt[1])
  );

  dac_spi_rx #(.DEVICE("AD5660"), .SYNC_STAGES(SYNC_STAGES)) u_ad5660 (
    .clk(clk), .reset(reset), .spi(bus),
    .dac_code(dacCode[2]), .cmd(cmdO[2]), .addr(addrO[2]),
    .valid(validO[2]), .frame_err(errO[2]),
    .frame_cnt(frameCnt[2]), .err_cnt(errCnt[2])
  );

  // Pulse monitor: every one-cycle strobe is seen exactly once on negedge.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (validO[d] === 1'b1) validSeen[d]++;
      if (errO[d] === 1'b1) errSeen[d]++;
      if (validO[d] === 1'b1 && errO[d] === 1'b1) bothSeen++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic int frameLen(input int d);
    return (d == 1) ? 16 : 24;
  endfunction

  // Reference model: a frame is a word of nbits bits; accept iff length
  // matches the device, then slice fields arithmetically.
  task automatic updateModel(input logic [127:0] word, input int nbits);
    int w;
    w = int'(word[23:0]);
    for (int d = 0; d < 3; d++) begin
      if (nbits == frameLen(d)) begin
        expValid[d]++;
        expFrames[d]++;
        case (d)
          0: begin
            expCmd[d]  = (w >> 20) & 15;
            expAddr[d] = (w >> 16) & 15;
            expCode[d] = w & 16'hFFFF;
          end
          1: begin
            expCmd[d]  = (w >> 14) & 3;
            expAddr[d] = 0;
            expCode[d] = ((w & 16'h3FFF) * 4) & 16'hFFFF;
          end
          default: begin
            expCmd[d]  = (w >> 16) & 3;
            expAddr[d] = 0;
            expCode[d] = w & 16'hFFFF;
          end
        endcase
      end else begin
        expErr[d]++;
        expErrs[d]++;
      end
    end
  endtask

  task automatic resetModel();
    for (int d = 0; d < 3; d++) begin
      expCode[d] = 0;
      expCmd[d] = 0;
      expAddr[d] = 0;
      expFrames[d] = 0;
      expErrs[d] = 0;
    end
  endtask

  task automatic checkAll(input string step);
    int fc;
    int ec;
    for (int d = 0; d < 3; d++) begin
`ifdef DAC_SPI_RX_STATS_EN
      fc = expFrames[d] & 16'hFFFF;
      ec = expErrs[d] & 16'hFFFF;
`else
      fc = 0;
      ec = 0;
`endif
      checkOutput($sformatf("%s.d%0d.validPulses", step, d), 32'(validSeen[d]), 32'(expValid[d]));
      checkOutput($sformatf("%s.d%0d.errPulses", step, d), 32'(errSeen[d]), 32'(expErr[d]));
      checkOutput($sformatf("%s.d%0d.dacCode", step, d), 32'(dacCode[d]), 32'(expCode[d]));
      checkOutput($sformatf("%s.d%0d.cmd", step, d), 32'(cmdO[d]), 32'(expCmd[d]));
      checkOutput($sformatf("%s.d%0d.addr", step, d), 32'(addrO[d]), 32'(expAddr[d]));
      checkOutput($sformatf("%s.d%0d.frameCnt", step, d), 32'(frameCnt[d]), 32'(fc));
      checkOutput($sformatf("%s.d%0d.errCnt", step, d), 32'(errCnt[d]), 32'(ec));
    end
  endtask

  // Shift nbits of word MSB-first; optionally raise sync_n together with
  // the last sclk rise.
  task automatic sendBits(input logic [127:0] word, input int nbits, input bit sameEdge);
    for (int i = nbits - 1; i >= 0; i--) begin
      bus.mosi = word[i];
      repeat (2) @(negedge clk);
      if (i == 0 && sameEdge) begin
        bus.sclk = 1'b1;
        bus.sync_n = 1'b1;
      end else begin
        bus.sclk = 1'b1;
        repeat (3) @(negedge clk);
        bus.sclk = 1'b0;
        repeat (2) @(negedge clk);
      end
    end
  endtask

  // sclk toggling while no frame is open must be ignored.
  task automatic idleSclk(input int n);
    for (int i = 0; i < n; i++) begin
      bus.mosi = 1'($urandom);
      bus.sclk = 1'b1;
      repeat (2) @(negedge clk);
      bus.sclk = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic applyStimulus(input string step, input logic [127:0] word, input int nbits, input bit sameEdge);
    int latency;
    @(negedge clk);
    bus.sync_n = 1'b0;
    repeat (3) @(negedge clk);
    sendBits(word, nbits, sameEdge);
    bus.sync_n = 1'b1;
    latency = -1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk);
      #1;
      if (validO[0] === 1'b1 || errO[0] === 1'b1) begin
        latency = e;
        break;
      end
    end
    repeat (6) @(negedge clk);
    bus.sclk = 1'b0;
    repeat (2) @(negedge clk);
    updateModel(word, nbits);
    checkOutput({step, ".latency"}, 32'(latency), 32'(SYNC_STAGES + 2));
    checkAll(step);
  endtask

  initial begin
    logic [127:0] w;
    int n;
    reset = 1'b1;
    bus.sclk = 1'b0;
    bus.mosi = 1'b0;
    bus.sync_n = 1'b1;
    resetModel();
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    checkAll("reset");

    applyStimulus("ltc30ABCD", 128'h30ABCD, 24, 1'b0);
    applyStimulus("ad5640_3FFF", 128'h3FFF, 16, 1'b0);
    applyStimulus("ad5640_8001", 128'h8001, 16, 1'b0);
    applyStimulus("trunc20", 128'hABCDE, 20, 1'b0);
    w = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus("long70", w, 70, 1'b0);
    applyStimulus("afterLong", 128'h5A9C3E, 24, 1'b0);
    applyStimulus("sameEdge", 128'h7F0155, 24, 1'b1);

    // Reset in the middle of a frame: partial frame must vanish silently.
    @(negedge clk);
    bus.sync_n = 1'b0;
    repeat (3) @(negedge clk);
    w = {$urandom, $urandom, $urandom, $urandom};
    sendBits(w, 10, 1'b0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    bus.sync_n = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    resetModel();
    repeat (6) @(negedge clk);
    checkAll("midReset");
    applyStimulus("post301234", 128'h301234, 24, 1'b0);

    for (int k = 0; k < 12; k++) begin
      idleSclk(int'($urandom_range(0, 3)));
      w = {$urandom, $urandom, $urandom, $urandom};
      case ($urandom_range(0, 4))
        0, 1: n = 16;
        2, 3: n = 24;
        default: n = int'($urandom_range(1, 40));
      endcase
      applyStimulus($sformatf("rand%0d", k), w, n, 1'($urandom));
    end

    checkOutput("neverBoth", 32'(bothSeen), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
